frac_strober: RTL
=================

// Module: frac_strober
// PURPOSE
//   Fractional-rate strobe generator: emits num/den single-cycle strobes per enabled clock.
//   Uses a Bresenham accumulator. The block paces DSP stages whose rate is not an integer
//   divisor of clk, e.g. FM modulator interpolation and sample-rate conversion.
//   Adds runtime rate reload, resync and config error reporting.
// PARAMETERS
//   WIDTH  16  width of num, den, accumulator and strobe counter
// PORTS
//   clk        in   1      system clock
//   rst        in   1      synchronous, active-high reset
//   enable     in   1      advance accumulator this cycle
//   num        in   WIDTH  rate numerator, sampled on load
//   den        in   WIDTH  rate denominator, sampled on load
//   load       in   1      capture num/den
//   sync       in   1      realign phase: clear accumulator
//   stb_out    out  1      registered strobe, one cycle wide
//   cfg_err    out  1      last loaded config invalid
//   running    out  1      state == RUN
//   stb_count  out  WIDTH  strobes emitted, wraps at 2^WIDTH
// BEHAVIOUR
//   Clock and reset: one clock; reset is synchronous and active-high.
//   - rst wins over all inputs, including enable.
//   - Reset values: state=IDLE, acc=0, cur/pend cfg=0, pend_vld=0.
//   - Reset values (outputs): stb_out=0, cfg_err=0, running=0, stb_count=0.
//   Validity: a config is valid iff den!=0 and num<=den.
//   States:
//   - IDLE: no config applied; stb_out=0.
//   - RUN: accumulating.
//   - ERR: invalid config loaded; stb_out=0, cfg_err=1.
//   Load, all states:
//   - valid load from IDLE/ERR: -> RUN next cycle, cur=num/den, acc=0, cfg_err=0.
//   - invalid load in any state: -> ERR, pend_vld=0.
//   - valid load in RUN: pend=num/den, pend_vld=1 (a later load overwrites pend).
//   Accumulate (RUN & enable & ~sync):
//   - s = acc + cur_num, computed WIDTH+1 bits wide (no overflow).
//   - if s >= cur_den: strobe decision, acc <= s - cur_den.
//   - else: acc <= s.
//   - stb_out is high the cycle after the decision (latency 1); stb_count increments
//     on that same cycle.
//   - enable low: acc holds, stb_out=0.
//   Pending reload:
//   - applied on a decision cycle: cur<=pend, acc<=0, pend_vld=0.
//   - the strobe for that decision is still emitted.
//   - a load in the same cycle as a decision is captured into pend only; it does not
//     apply that cycle.
//   sync:
//   - acc<=0 next cycle; no decision that cycle even if enable=1.
//   - pend is kept.
//   - sync+load same cycle: the load rules apply, acc=0.
//   Boundaries:
//   - num=0: RUN, never strobes.
//   - num=den: strobe every enabled cycle.
//   - den=2^WIDTH-1, num=den: no overflow, since s is WIDTH+1 bits.
//   - rst mid-RUN: config is lost; a new load is required.
// TESTING
//   1. rst, load num=1 den=1, enable=1 -> running next cycle; stb_out high every cycle
//      from 2nd enabled cycle; stb_count counts 1,2,3.
//   2. num=3 den=8, enable=1 -> decisions at enabled cycles 3,6,8 of each 8; 300 strobes
//      in 800 cycles.
//   3. num=3 den=8, enable toggled 50% -> strobes only follow enabled-cycle decisions;
//      150 strobes in 800 clocks.
//   4. RUN 1/4, load 1/2 at acc=2 -> one more strobe at 1/4 timing, then 1/2 pattern
//      from acc=0.
//   5. load num=5 den=3 -> cfg_err=1, running=0, stb_out=0; then load 1/2 -> cfg_err=0,
//      RUN.
//   6. rst asserted with enable=1 mid-RUN -> all outputs 0 next cycle; sync mid-cycle
//      -> next decision exactly den/num cycles later.

Source files
------------

// File: rtl/frac_strober_if.sv
// Handshake bundle for the fractional strober: rate config, control strobes and status.
// The testbench drives through master; the strober sits on slave.
interface frac_strober_if #(parameter int WIDTH = 16);
    logic             enable;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic             load;
    logic             sync;
    logic             stb_out;
    logic             cfg_err;
    logic             running;
    logic [WIDTH-1:0] stb_count;

    modport master (
        output enable, num, den, load, sync,
        input  stb_out, cfg_err, running, stb_count
    );

    modport slave (
        input  enable, num, den, load, sync,
        output stb_out, cfg_err, running, stb_count
    );
endinterface

// File: rtl/frac_strober.sv
// Fractional-rate strobe generator: num/den single-cycle strobes per enabled clock,
// Bresenham accumulator with deferred rate reload, phase resync and config error flag.
//
// state | meaning
// IDLE  | no config applied, no strobes
// RUN   | accumulating cur_num against cur_den
// ERR   | last loaded config invalid, no strobes
module frac_strober #(
    parameter int WIDTH = 16
) (
    input logic          clk,
    input logic          rst,
    frac_strober_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] cur_num;
    logic [WIDTH-1:0] cur_den;
    logic [WIDTH-1:0] pend_num;
    logic [WIDTH-1:0] pend_den;
    logic             pend_vld;
    logic             stb_out;
    logic [WIDTH-1:0] stb_count;

    // One extra bit on the sum keeps num=den=2^WIDTH-1 from wrapping.
    logic [WIDTH:0]   sum;
    logic             cfg_ok;
    logic             decide;

    always_comb begin
        sum    = {1'b0, acc} + {1'b0, cur_num};
        cfg_ok = (bus.den != '0) && (bus.num <= bus.den);
        decide = (state == RUN) && bus.enable && !bus.sync && (sum >= {1'b0, cur_den});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cur_num   <= '0;
            cur_den   <= '0;
            pend_num  <= '0;
            pend_den  <= '0;
            pend_vld  <= 1'b0;
            stb_out   <= 1'b0;
            stb_count <= '0;
        end else begin
            stb_out <= 1'b0;
            if (bus.load && !cfg_ok) begin
                state    <= ERR;
                pend_vld <= 1'b0;
                acc      <= '0;
            end else if (bus.load && state != RUN) begin
                state   <= RUN;
                cur_num <= bus.num;
                cur_den <= bus.den;
                acc     <= '0;
            end else if (state == RUN) begin
                if (bus.sync) begin
                    acc <= '0;
                end else if (decide) begin
                    stb_out   <= 1'b1;
                    stb_count <= stb_count + 1'b1;
                    if (pend_vld) begin
                        cur_num  <= pend_num;
                        cur_den  <= pend_den;
                        acc      <= '0;
                        pend_vld <= 1'b0;
                    end else begin
                        acc <= WIDTH'(sum - {1'b0, cur_den});
                    end
                end else if (bus.enable) begin
                    acc <= WIDTH'(sum);
                end
                // A load landing on a decision cycle waits for the next decision.
                if (bus.load) begin
                    pend_num <= bus.num;
                    pend_den <= bus.den;
                    pend_vld <= 1'b1;
                end
            end
        end
    end

    assign bus.stb_out   = stb_out;
    assign bus.stb_count = stb_count;
    assign bus.running   = (state == RUN);
    assign bus.cfg_err   = (state == ERR);
endmodule
